// File: rtl/pcomp_multi.sv
// Multi-channel position-compare engine. NCH independent channels share one
// signed position bus; each emits a pulse train at regularly spaced positions.
module pcomp_multi #(
  parameter int POSN_W = 32,
  parameter int CNT_W  = 32,
  parameter int NCH    = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic signed [POSN_W-1:0] posn_i,
  input  logic [NCH-1:0]           enable_i,
  input  logic [NCH*POSN_W-1:0]    start_i,
  input  logic [NCH*POSN_W-1:0]    step_i,
  input  logic [NCH*POSN_W-1:0]    width_i,
  input  logic [NCH*CNT_W-1:0]     num_i,
  input  logic [NCH*POSN_W-1:0]    deltap_i,
  input  logic [NCH-1:0]           dir_i,
  input  logic [NCH-1:0]           relative_i,
  output logic [NCH-1:0]           act_o,
  output logic [NCH-1:0]           out_o,
  output logic [NCH*2-1:0]         err_o,
  output logic [NCH*CNT_W-1:0]     pcount_o
);

  // Two guard bits keep start/step/width/deltap sums from wrapping.
  localparam int EW = POSN_W + 2;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_SKIP = 2'd1;
  localparam logic [1:0] ERR_REV  = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARM   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_PULSE = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERR   = 3'd5
  } state_t;

  function automatic logic reached(input logic signed [EW-1:0] p,
                                   input logic signed [EW-1:0] x,
                                   input logic dir);
    return dir ? (p <= x) : (p >= x);
  endfunction

  logic signed [EW-1:0] posn_x_s;

  assign posn_x_s = {{2{posn_i[POSN_W-1]}}, posn_i};

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    state_t               state_r;
    logic signed [EW-1:0] pk_r;
    logic signed [EW-1:0] step_r;
    logic signed [EW-1:0] width_r;
    logic signed [EW-1:0] deltap_r;
    logic [CNT_W-1:0]     num_r;
    logic [CNT_W-1:0]     pcount_r;
    logic                 dir_r;
    logic                 act_r;
    logic                 out_r;
    logic [1:0]           err_r;

    logic signed [EW-1:0] start_x_s;
    logic signed [EW-1:0] origin_s;
    logic signed [EW-1:0] pitch_s;
    logic signed [EW-1:0] pend_s;
    logic signed [EW-1:0] arm_lim_s;
    logic [CNT_W-1:0]     pcount_inc_s;
    logic                 arm_ok_s;
    logic                 retreat_s;
    logic                 hit_start_s;
    logic                 hit_end_s;
    logic                 last_s;

    // Direction-dependent compare points derived from the latched settings.
    always_comb begin
      start_x_s = {{2{start_i[c*POSN_W+POSN_W-1]}}, start_i[c*POSN_W +: POSN_W]};
      origin_s  = relative_i[c] ? posn_x_s : {EW{1'b0}};
      if (dir_r) begin
        pitch_s   = -step_r;
        pend_s    = pk_r - width_r;
        arm_lim_s = pk_r + deltap_r;
        arm_ok_s  = (posn_x_s >= arm_lim_s);
        retreat_s = (posn_x_s > pk_r);
      end else begin
        pitch_s   = step_r;
        pend_s    = pk_r + width_r;
        arm_lim_s = pk_r - deltap_r;
        arm_ok_s  = (posn_x_s <= arm_lim_s);
        retreat_s = (posn_x_s < pk_r);
      end
      hit_start_s  = reached(posn_x_s, pk_r, dir_r);
      hit_end_s    = reached(posn_x_s, pend_s, dir_r);
      pcount_inc_s = pcount_r + {{(CNT_W-1){1'b0}}, 1'b1};
      last_s       = (num_r != {CNT_W{1'b0}}) && (pcount_inc_s == num_r);
    end

    // Channel FSM; all outputs are registered straight from this block.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        state_r  <= ST_IDLE;
        pk_r     <= {EW{1'b0}};
        step_r   <= {EW{1'b0}};
        width_r  <= {EW{1'b0}};
        deltap_r <= {EW{1'b0}};
        num_r    <= {CNT_W{1'b0}};
        pcount_r <= {CNT_W{1'b0}};
        dir_r    <= 1'b0;
        act_r    <= 1'b0;
        out_r    <= 1'b0;
        err_r    <= ERR_NONE;
      end else if (state_r == ST_IDLE) begin
        out_r <= 1'b0;
        if (enable_i[c]) begin
          // Being in IDLE with enable high is always an enable rise.
          pk_r     <= origin_s + start_x_s;
          step_r   <= {2'b00, step_i[c*POSN_W +: POSN_W]};
          width_r  <= {2'b00, width_i[c*POSN_W +: POSN_W]};
          deltap_r <= {2'b00, deltap_i[c*POSN_W +: POSN_W]};
          num_r    <= num_i[c*CNT_W +: CNT_W];
          dir_r    <= dir_i[c];
          pcount_r <= {CNT_W{1'b0}};
          err_r    <= ERR_NONE;
          act_r    <= 1'b1;
          state_r  <= ST_ARM;
        end else begin
          act_r <= 1'b0;
        end
      end else if (!enable_i[c]) begin
        out_r   <= 1'b0;
        act_r   <= 1'b0;
        state_r <= ST_IDLE;
      end else begin
        case (state_r)
          ST_ARM: begin
            if (arm_ok_s) begin
              state_r <= ST_WAIT;
            end else begin
              state_r <= ST_ARM;
            end
          end
          ST_WAIT: begin
            if (hit_end_s) begin
              err_r   <= ERR_SKIP;
              act_r   <= 1'b0;
              state_r <= ST_ERR;
            end else if (hit_start_s) begin
              out_r   <= 1'b1;
              state_r <= ST_PULSE;
            end else begin
              state_r <= ST_WAIT;
            end
          end
          ST_PULSE: begin
            if (retreat_s) begin
              out_r   <= 1'b0;
              err_r   <= ERR_REV;
              act_r   <= 1'b0;
              state_r <= ST_ERR;
            end else if (hit_end_s) begin
              out_r    <= 1'b0;
              pcount_r <= pcount_inc_s;
              pk_r     <= pk_r + pitch_s;
              if (last_s) begin
                act_r   <= 1'b0;
                state_r <= ST_DONE;
              end else begin
                state_r <= ST_WAIT;
              end
            end else begin
              state_r <= ST_PULSE;
            end
          end
          ST_DONE, ST_ERR: begin
            out_r <= 1'b0;
            act_r <= 1'b0;
          end
          default: begin
            out_r   <= 1'b0;
            act_r   <= 1'b0;
            state_r <= ST_IDLE;
          end
        endcase
      end
    end

    assign act_o[c]                     = act_r;
    assign out_o[c]                     = out_r;
    assign err_o[c*2 +: 2]              = err_r;
    assign pcount_o[c*CNT_W +: CNT_W]   = pcount_r;
  end

endmodule

// File: tb/tb_pcomp_multi.sv
// Scoreboard bench for pcomp_multi (NCH=2): expectations come from a closed-form
// model of the pulse train and are checked one clock after each posn sample.
module tb_pcomp_multi;

  localparam int PW = 32;
  localparam int CW = 32;
  localparam int NC = 2;

  logic                 clk_i = 1'b0;
  logic                 reset_n_i;
  logic signed [PW-1:0] posn_i;
  logic [NC-1:0]        enable_i;
  logic [NC*PW-1:0]     start_i;
  logic [NC*PW-1:0]     step_i;
  logic [NC*PW-1:0]     width_i;
  logic [NC*CW-1:0]     num_i;
  logic [NC*PW-1:0]     deltap_i;
  logic [NC-1:0]        dir_i;
  logic [NC-1:0]        relative_i;
  logic [NC-1:0]        act_o;
  logic [NC-1:0]        out_o;
  logic [NC*2-1:0]      err_o;
  logic [NC*CW-1:0]     pcount_o;

  typedef struct {
    int          ch;
    logic        act;
    logic        out;
    logic [1:0]  err;
    logic [31:0] pc;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  pcomp_multi #(.POSN_W(PW), .CNT_W(CW), .NCH(NC)) dut (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .posn_i     (posn_i),
    .enable_i   (enable_i),
    .start_i    (start_i),
    .step_i     (step_i),
    .width_i    (width_i),
    .num_i      (num_i),
    .deltap_i   (deltap_i),
    .dir_i      (dir_i),
    .relative_i (relative_i),
    .act_o      (act_o),
    .out_o      (out_o),
    .err_o      (err_o),
    .pcount_o   (pcount_o)
  );

  always #5 clk_i = ~clk_i;

  // Scoreboard consumer: outputs for the sample taken at this edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_i);
      #1;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        n_chk += 4;
        if (act_o[e.ch] !== e.act) begin
          n_fail++;
          $display("FAIL %s ch%0d act: got %b expected %b", e.tag, e.ch, act_o[e.ch], e.act);
        end
        if (out_o[e.ch] !== e.out) begin
          n_fail++;
          $display("FAIL %s ch%0d out: got %b expected %b posn=%0d", e.tag, e.ch, out_o[e.ch], e.out, posn_i);
        end
        if (err_o[e.ch*2 +: 2] !== e.err) begin
          n_fail++;
          $display("FAIL %s ch%0d err: got %0d expected %0d", e.tag, e.ch, err_o[e.ch*2 +: 2], e.err);
        end
        if (pcount_o[e.ch*CW +: CW] !== e.pc) begin
          n_fail++;
          $display("FAIL %s ch%0d pcount: got %0d expected %0d", e.tag, e.ch, pcount_o[e.ch*CW +: CW], e.pc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic set_ch(input int ch, input int start, input int step, input int width,
                        input int num, input int deltap, input logic dir, input logic rel);
    start_i[ch*PW +: PW]  = start;
    step_i[ch*PW +: PW]   = step;
    width_i[ch*PW +: PW]  = width;
    num_i[ch*CW +: CW]    = num;
    deltap_i[ch*PW +: PW] = deltap;
    dir_i[ch]             = dir;
    relative_i[ch]        = rel;
  endtask

  function automatic void push_fix(input int ch, input logic act, input logic out,
                                   input logic [1:0] err, input int pc, input string tag);
    sb.push_back('{ch, act, out, err, pc, tag});
  endfunction

  // Closed-form expectation for a channel that has armed and sees a monotonic ramp.
  function automatic void push_ramp(input int ch, input longint p, input longint base, input int dir,
                                    input longint step, input longint width, input longint num,
                                    input string tag);
    longint d, k, off, comp;
    logic   act, out;
    d = (dir != 0) ? (base - p) : (p - base);
    if (d < 0) begin
      comp = 0;
      out  = 1'b0;
    end else begin
      k    = d / step;
      off  = d % step;
      comp = k + ((off >= width) ? 1 : 0);
      out  = (off < width);
    end
    act = 1'b1;
    if (num != 0 && comp >= num) begin
      comp = num;
      act  = 1'b0;
      out  = 1'b0;
    end
    sb.push_back('{ch, act, out, 2'd0, comp[31:0], tag});
  endfunction

  task automatic test_reset();
    reset_n_i = 1'b0;
    posn_i = 0; enable_i = '0; start_i = '0; step_i = '0; width_i = '0;
    num_i = '0; deltap_i = '0; dir_i = '0; relative_i = '0;
    repeat (2) @(posedge clk_i);
    #2;
    n_chk += 4;
    if (act_o !== 2'b00) begin n_fail++; $display("FAIL reset act: got %b expected 00", act_o); end
    if (out_o !== 2'b00) begin n_fail++; $display("FAIL reset out: got %b expected 00", out_o); end
    if (err_o !== 4'h0) begin n_fail++; $display("FAIL reset err: got %h expected 0", err_o); end
    if (pcount_o !== 64'd0) begin n_fail++; $display("FAIL reset pcount: got %h expected 0", pcount_o); end
    reset_n_i = 1'b1;
    tick();
  endtask

  task automatic test_neg_train();
    set_ch(0, 1000, 100, 50, 100, 10, 1'b0, 1'b0);
    set_ch(1, 4000, 100, 50, 100, 100, 1'b1, 1'b0);
    posn_i = 5000; enable_i = 2'b11;
    push_fix(0, 1'b1, 1'b0, 2'd0, 0, "train_arm");
    push_ramp(1, 5000, 4000, 1, 100, 50, 100, "train");
    tick();
    for (int p = 4999; p >= 3700; p--) begin
      posn_i = p;
      push_fix(0, 1'b1, 1'b0, 2'd0, 0, "train_arm");
      push_ramp(1, p, 4000, 1, 100, 50, 100, "train");
      tick();
    end
    enable_i = 2'b00;
    push_fix(0, 1'b0, 1'b0, 2'd0, 0, "train_off");
    push_fix(1, 1'b0, 1'b0, 2'd0, 3, "train_off");
    tick();
  endtask

  task automatic test_skip();
    posn_i = 5000; enable_i = 2'b11;
    push_fix(0, 1'b1, 1'b0, 2'd0, 0, "skip_arm");
    push_ramp(1, 5000, 4000, 1, 100, 50, 100, "skip");
    tick();
    for (int p = 4999; p >= 3801; p--) begin
      posn_i = p;
      push_fix(0, 1'b1, 1'b0, 2'd0, 0, "skip_arm");
      push_ramp(1, p, 4000, 1, 100, 50, 100, "skip");
      tick();
    end
    for (int p = 3750; p >= 3700; p--) begin
      posn_i = p;
      push_fix(0, 1'b1, 1'b0, 2'd0, 0, "skip_arm");
      push_fix(1, 1'b0, 1'b0, 2'd1, 2, "skip_err");
      tick();
    end
    enable_i = 2'b00;
    push_fix(0, 1'b0, 1'b0, 2'd0, 0, "skip_off");
    push_fix(1, 1'b0, 1'b0, 2'd1, 2, "skip_hold");
    tick();
  endtask

  task automatic test_enable_pulse();
    enable_i = 2'b10;
    push_fix(1, 1'b1, 1'b0, 2'd0, 0, "en_pulse_rise");
    tick();
    enable_i = 2'b00;
    push_fix(1, 1'b0, 1'b0, 2'd0, 0, "en_pulse_fall");
    tick();
    push_fix(1, 1'b0, 1'b0, 2'd0, 0, "en_pulse_idle");
    tick();
  endtask

  task automatic test_num_limit();
    set_ch(0, 1000, 100, 50, 3, 50, 1'b0, 1'b0);
    posn_i = 800; enable_i = 2'b01;
    push_ramp(0, 800, 1000, 0, 100, 50, 3, "num");
    push_fix(1, 1'b0, 1'b0, 2'd0, 0, "num_ch1");
    tick();
    for (int p = 801; p <= 1400; p++) begin
      posn_i = p;
      if (p == 900) start_i[PW-1:0] = 32'd5000;
      push_ramp(0, p, 1000, 0, 100, 50, 3, "num");
      tick();
    end
    enable_i = 2'b00;
    push_fix(0, 1'b0, 1'b0, 2'd0, 3, "num_off");
    tick();
  endtask

  task automatic test_relative();
    set_ch(0, 100, 100, 50, 1, 20, 1'b0, 1'b1);
    posn_i = 2000; enable_i = 2'b01;
    push_ramp(0, 2000, 2100, 0, 100, 50, 1, "rel");
    tick();
    for (int p = 2001; p <= 2200; p++) begin
      posn_i = p;
      push_ramp(0, p, 2100, 0, 100, 50, 1, "rel");
      tick();
    end
    enable_i = 2'b00;
    push_fix(0, 1'b0, 1'b0, 2'd0, 1, "rel_off");
    tick();
  endtask

  task automatic test_reversal();
    set_ch(0, 1000, 100, 50, 0, 20, 1'b0, 1'b0);
    posn_i = 950; enable_i = 2'b01;
    push_ramp(0, 950, 1000, 0, 100, 50, 0, "rev");
    tick();
    for (int p = 951; p <= 1020; p++) begin
      posn_i = p;
      push_ramp(0, p, 1000, 0, 100, 50, 0, "rev");
      tick();
    end
    posn_i = 990;
    push_fix(0, 1'b0, 1'b0, 2'd2, 0, "rev_err");
    tick();
    posn_i = 1030;
    push_fix(0, 1'b0, 1'b0, 2'd2, 0, "rev_hold");
    tick();
    enable_i = 2'b00;
    push_fix(0, 1'b0, 1'b0, 2'd2, 0, "rev_off");
    tick();
  endtask

  task automatic test_async_reset();
    posn_i = 950; enable_i = 2'b01;
    push_ramp(0, 950, 1000, 0, 100, 50, 0, "prerst");
    tick();
    for (int p = 951; p <= 1120; p++) begin
      posn_i = p;
      push_ramp(0, p, 1000, 0, 100, 50, 0, "prerst");
      tick();
    end
    #3;
    reset_n_i = 1'b0;
    #1;
    n_chk += 4;
    if (act_o !== 2'b00) begin n_fail++; $display("FAIL async_rst act: got %b expected 00", act_o); end
    if (out_o !== 2'b00) begin n_fail++; $display("FAIL async_rst out: got %b expected 00", out_o); end
    if (err_o !== 4'h0) begin n_fail++; $display("FAIL async_rst err: got %h expected 0", err_o); end
    if (pcount_o !== 64'd0) begin n_fail++; $display("FAIL async_rst pcount: got %h expected 0", pcount_o); end
    enable_i = 2'b00;
    tick();
    tick();
    reset_n_i = 1'b1;
    push_fix(0, 1'b0, 1'b0, 2'd0, 0, "post_rst");
    push_fix(1, 1'b0, 1'b0, 2'd0, 0, "post_rst");
    tick();
  endtask

  task automatic test_reenable();
    posn_i = 950; enable_i = 2'b01;
    push_ramp(0, 950, 1000, 0, 100, 50, 0, "reen");
    tick();
    for (int p = 951; p <= 1160; p++) begin
      posn_i = p;
      push_ramp(0, p, 1000, 0, 100, 50, 0, "reen");
      tick();
    end
    enable_i = 2'b00;
    push_fix(0, 1'b0, 1'b0, 2'd0, 2, "reen_off");
    tick();
  endtask

  initial begin
    test_reset();
    test_neg_train();
    test_skip();
    test_enable_pulse();
    test_num_limit();
    test_relative();
    test_reversal();
    test_async_reset();
    test_reenable();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pcomp_multi.md
Name: pcomp_multi

Overview:
- NCH-channel position-compare engine; successor to the single-channel pcomp.
- All channels share one encoder position bus. Each channel has its own START/STEP/WIDTH/NUM/DIR/DELTAP/RELATIVE settings and its own enable.
- Emits a pulse train at regularly spaced positions, plus per-channel active, error-code and pulse-count readback.
- Sits between the position bus and the output pulse routing.

Parameters:
- POSN_W, 32, signed position width.
- CNT_W, 32, pulse counter / NUM width.
- NCH, 4, number of independent compare channels (1..8).

Ports:
- clk_i  in  1  system clock.
- reset_n_i  in  1  asynchronous active-low reset.
- posn_i  in  POSN_W  signed position, sampled every cycle.
- enable_i  in  NCH  per-channel enable, level-sensitive.
- start_i  in  NCH*POSN_W  signed first pulse position, channel c at bits [c*POSN_W +: POSN_W].
- step_i  in  NCH*POSN_W  unsigned pulse pitch, nonzero.
- width_i  in  NCH*POSN_W  unsigned pulse width, must be < step.
- num_i  in  NCH*CNT_W  pulse count; 0 = unlimited.
- deltap_i  in  NCH*POSN_W  unsigned arming distance.
- dir_i  in  NCH  0 = positive, 1 = negative.
- relative_i  in  NCH  1 = start relative to position latched at enable.
- act_o  out  NCH  channel armed or running.
- out_o  out  NCH  compare pulse.
- err_o  out  NCH*2  error code: 0 none, 1 skipped pulse, 2 direction reversal during pulse.
- pcount_o  out  NCH*CNT_W  completed pulses since enable.

Behaviour:
- Reset (async assert, sync deassert to clk_i): all outputs 0, all channels IDLE.
- Channels are fully independent. Settings are latched on the enable rising edge; changes while enabled are ignored.
- Definitions:
  - sgn = +1 if dir=0, -1 if dir=1.
  - origin = posn_i at the enable rise if relative=1, else 0.
  - Pulse k nominal start Pk = origin + start + sgn*k*step.
- Arithmetic: signed, POSN_W+2 bits internally; no wrap-around of positions.
- "Reached X" means posn >= X for dir=0 and posn <= X for dir=1.
- Per-channel FSM:
  - IDLE: on enable rise → latch settings, err := 0, pcount := 0, k := 0, act := 1 → ARM.
  - ARM: wait until posn is at least deltap before P0 against the direction, i.e. posn <= P0 - deltap (dir=0) or posn >= P0 + deltap (dir=1) → WAIT.
  - WAIT:
    - if posn reached Pk + sgn*width in one sample → err := 1, act := 0 → ERR;
    - else if posn reached Pk → out := 1 → PULSE.
  - PULSE:
    - if posn retreats past Pk against the direction (posn < Pk for dir=0, > Pk for dir=1) → out := 0, err := 2, act := 0 → ERR;
    - else if posn reached Pk + sgn*width → out := 0, pcount++, k++; then if num≠0 and pcount == num → act := 0 → DONE, else → WAIT.
  - DONE / ERR: outputs held (out=0, act=0, err and pcount retained); leave only on enable fall → IDLE.
- Enable fall in any state → IDLE next cycle, out := 0, act := 0; err and pcount retained until the next enable rise.
- Latency: out_o/act_o/err_o change exactly 1 clk after the posn_i sample that causes them.
- If a single sample both reaches Pk and passes Pk + width, it is an error (code 1); no pulse is emitted.
- Enable rise and fall in consecutive cycles: the channel spends exactly one cycle in ARM.

Test Plan:
- NCH=2, absolute:
  - ch0: start=1000, step=100, width=50, num=100, dir=0.
  - ch1: start=4000, step=100, width=50, num=100, dir=1.
  - Enable both at posn=5000, then decrement by 1 every 125 clk.
  - Required: ch0 stays in ARM (act=1, out=0) throughout.
  - Required: ch1 out high at posn 4000..3951, 3900..3851, …; pcount_o[1] increments on each falling edge.
- Same setup plus a jump 3801→3750 mid-descent.
  - Required: ch1 pulse at 3800 is skipped, err_o[1]=1, act_o[1]=0, out_o[1]=0; ch0 unaffected.
- ch0 dir=0, start=1000, step=100, width=50, num=3; ramp posn 800→1400 by +1.
  - Required: exactly 3 pulses, at 1000–1049, 1100–1149, 1200–1249; pcount=3; act falls 1 clk after posn=1250.
- ch0 relative=1, start=100; enable at posn=2000; ramp up.
  - Required: first pulse at posn 2100 after arming at posn <= 2000-deltap.
- In PULSE at posn 1020, step posn back to 990.
  - Required: err=2, out=0 1 clk later.
- Async reset (reset_n_i low) mid-pulse, asserted between clock edges.
  - Required: out/act/err/pcount all 0 immediately.
- After reset release, re-enable.
  - Required: normal ARM operation resumes.
